digital_lock_lockout_fsm: RTL and testbench
===========================================

// Module: digital_lock_lockout_fsm
// PURPOSE
//  Next-generation lock controller: parametrised key count, password length and display count.
//  Adds create/confirm password entry, failed-attempt counting and a timed lockout.
//  Sits between the key-press edge filter (one-cycle pulses in) and the 7-seg decoder.
//  Drives 4-bit digit codes for the decoder, and status LEDs.
// PARAMETERS
//  NUM_KEYS        4   keys/digit values (2..10); key[i] press enters digit value i
//  PASSWORD_LENGTH 4   digits per password (1..16)
//  NUM_DISPLAYS    6   7-seg digits driven, 4 bits each
//  MAX_ATTEMPTS    3   consecutive wrong entries before lockout (>=1)
//  ERROR_CYCLES    50000000  cycles the ERROR state is held
//  LOCKOUT_CYCLES  500000000 cycles the LOCKOUT state is held
// PORTS
//  clock            in   1   system clock, all logic on posedge
//  reset            in   1   asynchronous, active-low; clears all state
//  key              in   NUM_KEYS  one-cycle press pulses from edge filter
//  lock_flag        out  1   1 = password stored and door locked
//  error_flag       out  1   1 while in ERROR
//  enter_pwd_flag   out  1   1 while in ENTER
//  create_pwd_flag  out  1   1 while in CREATE or CONFIRM
//  lockout_flag     out  1   1 while in LOCKOUT
//  attempts_left    out  $clog2(MAX_ATTEMPTS+1)  MAX_ATTEMPTS - fail count
//  display_digits   out  4*NUM_DISPLAYS  digit codes; display 0 = bits [3:0]
// BEHAVIOUR
//  Reset (reset=0, async): state UNLOCKED; stored pwd, entry buffer, digit count, fail count,
//   timer = 0; all flags 0; attempts_left = MAX_ATTEMPTS; display all 4'hF (blank).
//  Valid press: exactly one key bit high. Zero or >1 bits high in a cycle: ignored, no effect.
//  All outputs registered; they reflect a press on the cycle after the pulse is sampled.
//  States and transitions:
//  - UNLOCKED: valid press -> CREATE (press not consumed as a digit); entry cleared.
//  - CREATE: each press shifts digit into entry; on digit PASSWORD_LENGTH, copy entry to
//     candidate, clear entry -> CONFIRM.
//  - CONFIRM: collect PASSWORD_LENGTH digits; equal to candidate -> store pwd, LOCKED;
//     else -> ERROR (return target UNLOCKED), candidate discarded.
//  - LOCKED: valid press -> ENTER (press not consumed); entry cleared.
//  - ENTER: collect PASSWORD_LENGTH digits; match -> UNLOCKED, fail count = 0, stored pwd kept
//     until next CREATE; mismatch -> fail count +1; if new count == MAX_ATTEMPTS -> LOCKOUT,
//     else ERROR (return target LOCKED).
//  - ERROR: timer counts to ERROR_CYCLES-1, then -> return target; keys ignored.
//  - LOCKOUT: timer counts to LOCKOUT_CYCLES-1, then fail count = 0 -> LOCKED; keys ignored.
//  Timer: zeroed on every state entry; saturates never (width $clog2(LOCKOUT_CYCLES)).
//  Fail count saturates at MAX_ATTEMPTS; only ENTER mismatches increment it.
//  Display: display 0 = most recent digit, display k = k-th previous; positions beyond
//   digit count show 4'hF. PASSWORD_LENGTH > NUM_DISPLAYS: oldest digits scroll off.
//   ERROR shows all 4'hE; LOCKOUT shows attempts-exhausted pattern all 4'hD; idle states blank.
//  Reset mid-entry or mid-lockout: immediate return to reset state; stored pwd lost.
// CONFIGURATION
//  DIGIT_ECHO_EN defined: entered digits shown as their values (0..NUM_KEYS-1).
//  DIGIT_ECHO_EN undefined: each entered position shows mask code 4'hC; count/scroll unchanged.
// TESTING
//  Run with small ERROR_CYCLES=4, LOCKOUT_CYCLES=16, MAX_ATTEMPTS=3, PASSWORD_LENGTH=4.
//  1 Reset, press k1, then 1,2,3,0 twice -> lock_flag=1 after 9th press, create_pwd_flag=0.
//  2 Locked; press any, then 1,2,3,0 -> lock_flag=0, attempts_left=3, display blank.
//  3 Locked; 3 wrong entries -> attempts_left 2,1,0; lockout_flag=1 for 16 cycles, then LOCKED,
//    attempts_left=3, keys during lockout ignored.
//  4 CONFIRM with 1,2,3,1 vs 1,2,3,0 -> error_flag=1 4 cycles, then UNLOCKED, lock_flag=0.
//  5 key=4'b0011 pulse during ENTER -> digit count unchanged, display unchanged.
//  6 reset asserted after 2 ENTER digits -> all outputs at reset values same cycle (async).
//  Run 1-2 with DIGIT_ECHO_EN on (display 0,3,2,1) and off (display C,C,C,C).

Source files
------------

// File: rtl/digital_lock_lockout_fsm.sv
// Lock controller: create/confirm password entry, failed-attempt counting, timed lockout.
// Optional DIGIT_ECHO_EN: show entered digit values instead of the mask code 4'hC.
module digital_lock_lockout_fsm #(
  parameter int NUM_KEYS        = 4,
  parameter int PASSWORD_LENGTH = 4,
  parameter int NUM_DISPLAYS    = 6,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int ERROR_CYCLES    = 50000000,
  parameter int LOCKOUT_CYCLES  = 500000000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_KEYS-1:0]                 key,
  output logic                                lock_flag,
  output logic                                error_flag,
  output logic                                enter_pwd_flag,
  output logic                                create_pwd_flag,
  output logic                                lockout_flag,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
  output logic [4*NUM_DISPLAYS-1:0]           display_digits
);
  localparam int PW = 4 * PASSWORD_LENGTH;
  localparam int CW = $clog2(PASSWORD_LENGTH + 1);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int XD = (NUM_DISPLAYS > PASSWORD_LENGTH) ? NUM_DISPLAYS : PASSWORD_LENGTH;
  localparam logic [TW-1:0] ERR_LAST  = TW'(ERROR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_DIG  = CW'(PASSWORD_LENGTH - 1);
  localparam logic [AW-1:0] MAX_A     = AW'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_UNLOCKED, S_CREATE, S_CONFIRM, S_LOCKED, S_ENTER, S_ERROR, S_LOCKOUT
  } state_t;

  state_t                    state_q, state_d, ret_q, ret_d;
  logic [PW-1:0]             entry_q, entry_d, cand_q, cand_d, pwd_q, pwd_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [AW-1:0]             fail_q, fail_d, fail_inc;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      lock_q, lock_d, err_q, err_d, ent_q, ent_d;
  logic                      cre_q, cre_d, lo_q, lo_d;
  logic [AW-1:0]             att_q, att_d;
  logic [4*NUM_DISPLAYS-1:0] disp_q, disp_d;

  logic                      press;
  logic [3:0]                digit;
  logic [PW+3:0]             shift_full;
  logic [PW-1:0]             shifted;
  logic [4*XD-1:0]           ext;
  logic [3:0]                code;

  always_comb begin
    press = $onehot(key);
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key[i]) digit = 4'(i);
    end
    shift_full = {entry_q, digit};
    shifted    = shift_full[PW-1:0];
    fail_inc   = (fail_q == MAX_A) ? fail_q : fail_q + AW'(1);
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    entry_d = entry_q;
    cand_d  = cand_q;
    pwd_d   = pwd_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      S_UNLOCKED: if (press) begin
        state_d = S_CREATE;
        entry_d = '0;
        cnt_d   = '0;
        pwd_d   = '0;
      end
      S_CREATE: if (press) begin
        if (cnt_q == LAST_DIG) begin
          cand_d  = shifted;
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_CONFIRM;
        end else begin
          entry_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_CONFIRM: if (press) begin
        if (cnt_q == LAST_DIG) begin
          entry_d = '0;
          cnt_d   = '0;
          cand_d  = '0;
          if (shifted == cand_q) begin
            pwd_d   = shifted;
            state_d = S_LOCKED;
          end else begin
            ret_d   = S_UNLOCKED;
            state_d = S_ERROR;
          end
        end else begin
          entry_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_LOCKED: if (press) begin
        state_d = S_ENTER;
        entry_d = '0;
        cnt_d   = '0;
      end
      S_ENTER: if (press) begin
        if (cnt_q == LAST_DIG) begin
          entry_d = '0;
          cnt_d   = '0;
          if (shifted == pwd_q) begin
            fail_d  = '0;
            state_d = S_UNLOCKED;
          end else begin
            fail_d  = fail_inc;
            ret_d   = S_LOCKED;
            state_d = (fail_inc == MAX_A) ? S_LOCKOUT : S_ERROR;
          end
        end else begin
          entry_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_ERROR:   if (timer_q == ERR_LAST) state_d = ret_q;
      S_LOCKOUT: if (timer_q == LOCK_LAST) begin
        fail_d  = '0;
        state_d = S_LOCKED;
      end
      default: state_d = S_UNLOCKED;
    endcase
    // Timer only runs while a timed state persists; any state change restarts it.
    timer_d = ((state_q == S_ERROR || state_q == S_LOCKOUT) && state_d == state_q)
              ? timer_q + TW'(1) : '0;
  end

  // Outputs are computed from next-state values so the registered copies line up with the state.
  always_comb begin
    lock_d = (state_d inside {S_LOCKED, S_ENTER, S_LOCKOUT}) ||
             (state_d == S_ERROR && ret_d == S_LOCKED);
    err_d  = (state_d == S_ERROR);
    ent_d  = (state_d == S_ENTER);
    cre_d  = (state_d inside {S_CREATE, S_CONFIRM});
    lo_d   = (state_d == S_LOCKOUT);
    att_d  = MAX_A - fail_d;
    ext    = '0;
    ext[PW-1:0] = entry_d;
    disp_d = '1;
    for (int k = 0; k < NUM_DISPLAYS; k++) begin
`ifdef DIGIT_ECHO_EN
      code = ext[k*4 +: 4];
`else
      code = 4'hC;
`endif
      if (state_d == S_ERROR)                  disp_d[k*4 +: 4] = 4'hE;
      else if (state_d == S_LOCKOUT)           disp_d[k*4 +: 4] = 4'hD;
      else if ((state_d inside {S_CREATE, S_CONFIRM, S_ENTER}) && (32'(cnt_d) > k))
                                               disp_d[k*4 +: 4] = code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_UNLOCKED;
      ret_q   <= S_UNLOCKED;
      entry_q <= '0;
      cand_q  <= '0;
      pwd_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      ent_q   <= 1'b0;
      cre_q   <= 1'b0;
      lo_q    <= 1'b0;
      att_q   <= MAX_A;
      disp_q  <= '1;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      entry_q <= entry_d;
      cand_q  <= cand_d;
      pwd_q   <= pwd_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      ent_q   <= ent_d;
      cre_q   <= cre_d;
      lo_q    <= lo_d;
      att_q   <= att_d;
      disp_q  <= disp_d;
    end
  end

  assign lock_flag       = lock_q;
  assign error_flag      = err_q;
  assign enter_pwd_flag  = ent_q;
  assign create_pwd_flag = cre_q;
  assign lockout_flag    = lo_q;
  assign attempts_left   = att_q;
  assign display_digits  = disp_q;
endmodule

// File: tb/tb_digital_lock_lockout_fsm.sv
// Directed scoreboard bench for digital_lock_lockout_fsm (small timer parameters).
module tb_digital_lock_lockout_fsm;
  localparam int NK = 4, PL = 4, ND = 6, MA = 3, EC = 4, LC = 16;
  localparam int AW = $clog2(MA + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NK-1:0]   key = '0;
  logic            lock_flag, error_flag, enter_pwd_flag, create_pwd_flag, lockout_flag;
  logic [AW-1:0]   attempts_left;
  logic [4*ND-1:0] display_digits;

  digital_lock_lockout_fsm #(
    .NUM_KEYS(NK), .PASSWORD_LENGTH(PL), .NUM_DISPLAYS(ND), .MAX_ATTEMPTS(MA),
    .ERROR_CYCLES(EC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clock(clock), .reset(reset), .key(key),
    .lock_flag(lock_flag), .error_flag(error_flag), .enter_pwd_flag(enter_pwd_flag),
    .create_pwd_flag(create_pwd_flag), .lockout_flag(lockout_flag),
    .attempts_left(attempts_left), .display_digits(display_digits)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic lock, err, ent, cre, lo;
    logic [AW-1:0] att;
    logic [4*ND-1:0] disp;
  } obs_t;

  obs_t  sbq[$];
  string tagq[$];
  int    n_cmp = 0, n_bad = 0;

  // Expected-output model: flags, attempts and a display mode (0 blank, 1 entry, 2 E, 3 D).
  logic e_lock, e_err, e_ent, e_cre, e_lo;
  int   e_att, mode;
  int   hist[$];

  function automatic obs_t build();
    obs_t o;
    logic [3:0] c;
    o.lock = e_lock; o.err = e_err; o.ent = e_ent; o.cre = e_cre; o.lo = e_lo;
    o.att  = AW'(e_att);
    for (int k = 0; k < ND; k++) begin
      c = 4'hF;
      if (mode == 2) c = 4'hE;
      else if (mode == 3) c = 4'hD;
      else if (mode == 1 && k < hist.size()) begin
`ifdef DIGIT_ECHO_EN
        c = 4'(hist[k]);
`else
        c = 4'hC;
`endif
      end
      o.disp[k*4 +: 4] = c;
    end
    return o;
  endfunction

  task automatic setx(input logic l, e, en, c, lo, input int a, m);
    e_lock = l; e_err = e; e_ent = en; e_cre = c; e_lo = lo; e_att = a; mode = m;
  endtask

  task automatic check();
    obs_t exp, act;
    string t;
    exp = sbq.pop_front();
    t   = tagq.pop_front();
    act = {lock_flag, error_flag, enter_pwd_flag, create_pwd_flag, lockout_flag,
           attempts_left, display_digits};
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", t, act, exp);
    end
  endtask

  task automatic chk_now(input string tag);
    sbq.push_back(build());
    tagq.push_back(tag);
    check();
  endtask

  task automatic cyc(input logic [NK-1:0] k, input string tag);
    sbq.push_back(build());
    tagq.push_back(tag);
    @(negedge clock);
    key = k;
    @(posedge clock);
    #1;
    key = '0;
    check();
  endtask

  task automatic dig(input int d, input string tag);
    hist.push_front(d);
    cyc(4'(1 << d), tag);
  endtask

  // From UNLOCKED: create and confirm 1,2,3,0, ending LOCKED.
  task automatic create_lock(input string tag);
    hist.delete();
    setx(0, 0, 0, 1, 0, MA, 1);
    cyc(4'b0010, {tag, "_start"});
    dig(1, {tag, "_c1"}); dig(2, {tag, "_c2"}); dig(3, {tag, "_c3"});
    hist.delete();
    cyc(4'b0001, {tag, "_c4"});
    dig(1, {tag, "_f1"}); dig(2, {tag, "_f2"}); dig(3, {tag, "_f3"});
    hist.delete();
    setx(1, 0, 0, 0, 0, MA, 0);
    cyc(4'b0001, {tag, "_locked"});
  endtask

  task automatic wrong_entry(input int att_before, input int att_after, input bit to_lockout);
    setx(1, 0, 1, 0, 0, att_before, 1);
    cyc(4'b0001, "t3_enter");
    dig(0, "t3_d1"); dig(0, "t3_d2"); dig(0, "t3_d3");
    hist.delete();
    if (to_lockout) setx(1, 0, 0, 0, 1, att_after, 3);
    else            setx(1, 1, 0, 0, 0, att_after, 2);
    cyc(4'b0001, "t3_wrong");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hist.delete();
    setx(0, 0, 0, 0, 0, MA, 0);
    repeat (2) @(negedge clock);
    chk_now("reset_state");
    reset = 1'b1;
    cyc(4'b0000, "idle_after_reset");

    // Test 1: create and confirm.
    create_lock("t1");

    // Test 2 with test 5 inserted mid-entry.
    hist.delete();
    setx(1, 0, 1, 0, 0, MA, 1);
    cyc(4'b1000, "t2_start");
    dig(1, "t2_d1"); dig(2, "t2_d2");
    cyc(4'b0011, "t5_multi_ignored");
    cyc(4'b1111, "t5_all_ignored");
    dig(3, "t2_d3");
    hist.delete();
    setx(0, 0, 0, 0, 0, MA, 0);
    cyc(4'b0001, "t2_unlocked");

    // Test 3: three wrong entries, error holds, then lockout.
    create_lock("t3pre");
    for (int n = 1; n <= 2; n++) begin
      wrong_entry(MA - n + 1, MA - n, 1'b0);
      cyc(4'b0000, "t3_err_hold");
      cyc(4'b0100, "t3_err_key_ignored");
      cyc(4'b0000, "t3_err_hold_last");
      setx(1, 0, 0, 0, 0, MA - n, 0);
      cyc(4'b0000, "t3_err_exit");
    end
    wrong_entry(1, 0, 1'b1);
    for (int i = 0; i < LC - 1; i++) cyc((i % 2) ? 4'b0010 : 4'b0000, "t3_lockout_hold");
    setx(1, 0, 0, 0, 0, MA, 0);
    cyc(4'b0000, "t3_lockout_exit");

    // Correct entry after lockout returns to UNLOCKED.
    setx(1, 0, 1, 0, 0, MA, 1);
    cyc(4'b0001, "t4pre_enter");
    dig(1, "t4pre_d1"); dig(2, "t4pre_d2"); dig(3, "t4pre_d3");
    hist.delete();
    setx(0, 0, 0, 0, 0, MA, 0);
    cyc(4'b0001, "t4pre_unlocked");

    // Test 4: confirm mismatch.
    setx(0, 0, 0, 1, 0, MA, 1);
    cyc(4'b0010, "t4_start");
    dig(1, "t4_c1"); dig(2, "t4_c2"); dig(3, "t4_c3");
    hist.delete();
    cyc(4'b0001, "t4_c4");
    dig(1, "t4_f1"); dig(2, "t4_f2"); dig(3, "t4_f3");
    hist.delete();
    setx(0, 1, 0, 0, 0, MA, 2);
    cyc(4'b0010, "t4_mismatch");
    cyc(4'b0000, "t4_err_hold1");
    cyc(4'b0000, "t4_err_hold2");
    cyc(4'b0000, "t4_err_hold3");
    setx(0, 0, 0, 0, 0, MA, 0);
    cyc(4'b0000, "t4_unlocked");

    // Test 6: asynchronous reset after two ENTER digits.
    create_lock("t6pre");
    setx(1, 0, 1, 0, 0, MA, 1);
    cyc(4'b0001, "t6_enter");
    dig(1, "t6_d1"); dig(2, "t6_d2");
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    hist.delete();
    setx(0, 0, 0, 0, 0, MA, 0);
    chk_now("t6_async_reset");
    @(negedge clock);
    reset = 1'b1;
    cyc(4'b0000, "t6_idle");
    setx(0, 0, 0, 1, 0, MA, 1);
    cyc(4'b0100, "t6_create_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
